// File: rtl/cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_fill_ctrl
//   Cache-miss fill controller. On a miss it fetches the aligned block that
//   contains miss_address, one word per cycle, from a pipelined backing
//   memory. Each returned word is strobed into the data array. The tag array
//   is written together with the last word.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   miss_detected       miss request (sampled only while idle)
//   miss_address        byte address of the missing access
//   mem_req             one read request per cycle to backing memory
//   memory_address      byte address of the current request
//   memory_data         read data returned by memory
//   memory_data_valid   memory_data valid (in request order)
//   fill_data           word to write into the data array
//   word_idx            data-array word index of the current write
//   write_data_array    one strobe per returned word
//   write_tag_array     strobe coincident with the last data write
//   fsm_busy            fill in progress (core stalls)
// ---------------------------------------------------------------------------
module cache_fill_ctrl #(
   parameter int  DATA_W          = 16,
   parameter int  ADDR_W          = 16,
   parameter int  WORDS_PER_BLOCK = 8,
   localparam int WIDX_W          = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              mem_req,
   output logic [ADDR_W-1:0] memory_address,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [WIDX_W-1:0] word_idx,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic              fsm_busy
);

   localparam int BYTES  = DATA_W / 8;
   localparam int BYTE_W = $clog2(BYTES);
   localparam int OFF_W  = WIDX_W + BYTE_W;
   localparam int CNT_W  = WIDX_W + 1;

   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, FILL} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
   logic              filling;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;

      filling   = (state_q == FILL);
      fsm_busy  = filling;
      fill_data = memory_data;
      word_idx  = rsp_cnt_q[WIDX_W-1:0];

      // Requests stream out back-to-back until the whole block is asked for.
      mem_req        = filling && (req_cnt_q < CNT_FULL);
      memory_address = '0;
      if (mem_req)
         memory_address = base_q + (ADDR_W'(req_cnt_q[WIDX_W-1:0]) << BYTE_W);

      // Valids seen while idle (late responses after reset) are dropped here.
      write_data_array = filling && memory_data_valid;
      write_tag_array  = write_data_array && (rsp_cnt_q == CNT_LAST);

      case (state_q)
         IDLE: begin
            if (miss_detected) begin
               state_d   = FILL;
               base_d    = miss_address & ~OFF_MASK;
               req_cnt_d = '0;
               rsp_cnt_d = '0;
            end
         end
         FILL: begin
            if (mem_req)          req_cnt_d = req_cnt_q + CNT_ONE;
            if (write_data_array) rsp_cnt_d = rsp_cnt_q + CNT_ONE;
            // Responses never outrun requests, so the last response ends the fill.
            if (write_tag_array)  state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
